sprite_layer_arbiter: RTL and testbench
=======================================

SPRITE_LAYER_ARBITER -- requirements
Module: sprite_layer_arbiter

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, giving the number of sprite color inputs arbitrated.
REQ-002 SHALL have parameter BG_COLOR, default 24'h00_00_00, the color output when no layer wins.
REQ-003 SHALL have port clk_in  input  1  system pixel clock.
REQ-004 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port hcount_in  input  11  current pixel column.
REQ-006 SHALL have port vcount_in  input  10  current pixel row.
REQ-007 SHALL have port layer_rgb_in  input  NUM_LAYERS x 24  per-layer color {R,G,B}, combinational sprite outputs.
REQ-008 SHALL have port cfg_valid_in  input  1  config write request.
REQ-009 SHALL have port cfg_ready_out  output  1  config write accepted this cycle when high with cfg_valid_in.
REQ-010 SHALL have port cfg_layer_in  input  2  layer index of the write.
REQ-011 SHALL have port cfg_enable_in  input  1  layer enable value written.
REQ-012 SHALL have port cfg_rank_in  input  2  layer priority rank written; lower rank wins.
REQ-013 SHALL have port cfg_commit_in  input  1  request that shadow config go live at next frame start.
REQ-014 SHALL have port commit_done_out  output  1  one-cycle pulse when the shadow config becomes active.
REQ-015 SHALL have ports red_out, green_out, blue_out  output  8 each  arbitrated pixel color.
REQ-016 SHALL have ports hcount_out (11) and vcount_out (10)  output  counts delayed to align with the color outputs.

Function
REQ-017 SHALL treat a layer pixel as transparent when all 24 bits are zero.
REQ-018 SHALL select, among enabled non-transparent layers, the one with lowest active rank; ties go to the lowest layer index.
REQ-019 SHALL output BG_COLOR when no layer qualifies.
REQ-020 SHALL have latency exactly 2 cycles: stage 1 registers the per-layer qualify mask, ranks and colors; stage 2 registers the selected color; hcount/vcount are delayed identically.
REQ-021 SHALL hold two config copies: shadow (written by cfg port) and active (used by the datapath).
REQ-022 SHALL implement FSM IDLE -> WAIT_FRAME -> IDLE.
REQ-023 IDLE: cfg_ready_out=1; a write with cfg_valid_in updates shadow[cfg_layer_in]; cfg_commit_in moves to WAIT_FRAME.
REQ-024 A write and a commit in the same IDLE cycle SHALL both take effect, the write being included in the commit.
REQ-025 WAIT_FRAME: cfg_ready_out=0; writes and commits ignored; on frame start (hcount_in==0 and vcount_in==0) copy shadow to active, pulse commit_done_out for one cycle, return to IDLE.
REQ-026 A commit accepted in the same cycle as a frame start SHALL wait for the following frame start.
REQ-027 The new active config SHALL govern the pixel sampled at the frame-start cycle's next cycle onward; pixel (0,0) uses the old config.
REQ-028 cfg_layer_in >= NUM_LAYERS SHALL be accepted and discarded.

Reset
REQ-029 On rst_in: FSM=IDLE; shadow and active enables all 1; rank of layer i = i (saturating at 3); pipeline colors=0, counts=0; commit_done_out=0.
REQ-030 Reset mid-WAIT_FRAME SHALL abandon the pending commit.

Structure
REQ-031 Config struct (enable, rank), FSM state enum and LAYER_IDX_W constant SHALL live in shared package sprite_pkg.
REQ-032 Priority selection SHALL be a sub-module layer_priority_select (combinational, mask+ranks -> winning index + valid).

Verification
REQ-033 Reset, layers 0..3 = FF0000, 00FF00, 0000FF, FFFFFF at (10,10) -> output FF0000 two cycles later with hcount_out=10.
REQ-034 Layer 0 = 000000, others as above -> 00FF00; all zero -> BG_COLOR.
REQ-035 Write layer 2 rank 0, layer 0 rank 3, commit mid-frame -> output unchanged until (0,0); commit_done_out pulses once; next pixel shows 0000FF.
REQ-036 In WAIT_FRAME drive cfg_valid_in with layer 1 disable -> cfg_ready_out=0, shadow unchanged after commit.
REQ-037 Layers 1 and 3 both rank 1, layer 0 disabled -> layer 1 color wins.
REQ-038 Assert rst_in during WAIT_FRAME -> no commit_done_out at next (0,0); defaults restored.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer arbiter: per-layer
// configuration record, config FSM states and the reset rank helper.
package sprite_pkg;

   localparam int LAYER_IDX_W = 2;
   localparam int RANK_W      = 2;
   localparam int COLOR_W     = 24;

   typedef struct packed {
      logic              enable;
      logic [RANK_W-1:0] rank;
   } layer_cfg_t;

   typedef enum logic [0:0] {
      ST_IDLE       = 1'b0,
      ST_WAIT_FRAME = 1'b1
   } arb_state_t;

   // Reset rank of layer idx equals its index, saturating at the largest rank.
   function automatic logic [RANK_W-1:0] reset_rank(input int idx);
      logic [RANK_W-1:0] r;
      if (idx >= 32'sd3) begin
         r = 2'd3;
      end else begin
         r = idx[RANK_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/layer_priority_select.sv
// Combinational priority picker: among the layers flagged in mask, returns
// the index with the lowest rank; equal ranks resolve to the lowest index.
module layer_priority_select
   import sprite_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int IDX_W      = 2
) (
   input  logic [NUM_LAYERS-1:0]        mask,
   input  logic [NUM_LAYERS*RANK_W-1:0] ranks,
   output logic [IDX_W-1:0]             win_idx,
   output logic                         win_valid
);

   logic [RANK_W-1:0] best_rank_s;
   logic              take_s;

   // Linear scan; a strict less-than keeps the earliest index on ties.
   always_comb begin
      win_idx     = {IDX_W{1'b0}};
      win_valid   = 1'b0;
      best_rank_s = {RANK_W{1'b1}};
      take_s      = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         take_s      = mask[i] && (!win_valid || (ranks[i*RANK_W +: RANK_W] < best_rank_s));
         win_idx     = take_s ? IDX_W'(i) : win_idx;
         best_rank_s = take_s ? ranks[i*RANK_W +: RANK_W] : best_rank_s;
         win_valid   = win_valid | take_s;
      end
   end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Sprite layer arbiter: picks the highest-priority opaque enabled layer per
// pixel through a two-stage pipeline. Configuration is written into a shadow
// copy and swapped into the live copy only at a frame start.
module sprite_layer_arbiter
   import sprite_pkg::*;
#(
   parameter int          NUM_LAYERS = 4,
   parameter logic [23:0] BG_COLOR   = 24'h00_00_00
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [10:0]                   hcount_in,
   input  logic [9:0]                    vcount_in,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_in,
   input  logic                          cfg_valid_in,
   output logic                          cfg_ready_out,
   input  logic [LAYER_IDX_W-1:0]        cfg_layer_in,
   input  logic                          cfg_enable_in,
   input  logic [RANK_W-1:0]             cfg_rank_in,
   input  logic                          cfg_commit_in,
   output logic                          commit_done_out,
   output logic [7:0]                    red_out,
   output logic [7:0]                    green_out,
   output logic [7:0]                    blue_out,
   output logic [10:0]                   hcount_out,
   output logic [9:0]                    vcount_out
);

   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   arb_state_t state_r;
   logic       ready_r;
   logic       commit_done_r;
   layer_cfg_t shadow_r [NUM_LAYERS];
   layer_cfg_t active_r [NUM_LAYERS];
   logic       frame_start_s;

   logic [NUM_LAYERS-1:0]         qualify_r;
   logic [NUM_LAYERS*RANK_W-1:0]  rank_r;
   logic [NUM_LAYERS*COLOR_W-1:0] color_r;
   logic [10:0]                   hcount_s1_r;
   logic [9:0]                    vcount_s1_r;

   logic [IDX_W-1:0]   win_idx_s;
   logic               win_valid_s;
   logic [COLOR_W-1:0] color_sel_s;

   logic [COLOR_W-1:0] rgb_r;
   logic [10:0]        hcount_s2_r;
   logic [9:0]         vcount_s2_r;

   assign frame_start_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);

   // Config FSM: shadow writes in IDLE, shadow-to-active swap at frame start.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r       <= ST_IDLE;
         ready_r       <= 1'b1;
         commit_done_r <= 1'b0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            shadow_r[i] <= '{enable: 1'b1, rank: reset_rank(i)};
            active_r[i] <= '{enable: 1'b1, rank: reset_rank(i)};
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               commit_done_r <= 1'b0;
               if (cfg_valid_in) begin
                  // Indices with no matching layer fall through and are dropped.
                  for (int i = 0; i < NUM_LAYERS; i++) begin
                     if (int'(cfg_layer_in) == i) begin
                        shadow_r[i] <= '{enable: cfg_enable_in, rank: cfg_rank_in};
                     end
                  end
               end
               if (cfg_commit_in) begin
                  state_r <= ST_WAIT_FRAME;
                  ready_r <= 1'b0;
               end
            end
            ST_WAIT_FRAME: begin
               if (frame_start_s) begin
                  for (int i = 0; i < NUM_LAYERS; i++) begin
                     active_r[i] <= shadow_r[i];
                  end
                  commit_done_r <= 1'b1;
                  state_r       <= ST_IDLE;
                  ready_r       <= 1'b1;
               end else begin
                  commit_done_r <= 1'b0;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               ready_r       <= 1'b1;
               commit_done_r <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: capture per-layer qualify flag, live rank, color and counts.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         qualify_r   <= {NUM_LAYERS{1'b0}};
         rank_r      <= {(NUM_LAYERS*RANK_W){1'b0}};
         color_r     <= {(NUM_LAYERS*COLOR_W){1'b0}};
         hcount_s1_r <= 11'd0;
         vcount_s1_r <= 10'd0;
      end else begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            qualify_r[i] <= active_r[i].enable &&
                            (layer_rgb_in[i*COLOR_W +: COLOR_W] != 24'h00_00_00);
            rank_r[i*RANK_W +: RANK_W] <= active_r[i].rank;
         end
         color_r     <= layer_rgb_in;
         hcount_s1_r <= hcount_in;
         vcount_s1_r <= vcount_in;
      end
   end

   layer_priority_select #(
      .NUM_LAYERS (NUM_LAYERS),
      .IDX_W      (IDX_W)
   ) u_select (
      .mask      (qualify_r),
      .ranks     (rank_r),
      .win_idx   (win_idx_s),
      .win_valid (win_valid_s)
   );

   // Winning layer color, or the background when nothing qualifies.
   always_comb begin
      color_sel_s = BG_COLOR;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         color_sel_s = (win_valid_s && (win_idx_s == IDX_W'(i))) ?
                       color_r[i*COLOR_W +: COLOR_W] : color_sel_s;
      end
   end

   // Stage 2: register the selected color and the aligned counts.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rgb_r       <= 24'h00_00_00;
         hcount_s2_r <= 11'd0;
         vcount_s2_r <= 10'd0;
      end else begin
         rgb_r       <= color_sel_s;
         hcount_s2_r <= hcount_s1_r;
         vcount_s2_r <= vcount_s1_r;
      end
   end

   assign cfg_ready_out   = ready_r;
   assign commit_done_out = commit_done_r;
   assign red_out         = rgb_r[23:16];
   assign green_out       = rgb_r[15:8];
   assign blue_out        = rgb_r[7:0];
   assign hcount_out      = hcount_s2_r;
   assign vcount_out      = vcount_s2_r;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Self-checking bench for sprite_layer_arbiter: a scoreboard queue holds the
// expected pixel for every driven cycle and is checked two cycles later.
module tb_sprite_layer_arbiter;

   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GRN   = 24'h00FF00;
   localparam logic [23:0] BLU   = 24'h0000FF;
   localparam logic [23:0] WHT   = 24'hFFFFFF;
   localparam logic [23:0] BLACK = 24'h000000;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [95:0] layer_rgb_in;
   logic        cfg_valid_in;
   logic        cfg_ready_out;
   logic [1:0]  cfg_layer_in;
   logic        cfg_enable_in;
   logic [1:0]  cfg_rank_in;
   logic        cfg_commit_in;
   logic        commit_done_out;
   logic [7:0]  red_out, green_out, blue_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        chk;
      logic [23:0] color;
      logic [10:0] h;
      logic [9:0]  v;
   } exp_t;
   exp_t sb[$];

   sprite_layer_arbiter #(.NUM_LAYERS(4), .BG_COLOR(24'h000000)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .layer_rgb_in    (layer_rgb_in),
      .cfg_valid_in    (cfg_valid_in),
      .cfg_ready_out   (cfg_ready_out),
      .cfg_layer_in    (cfg_layer_in),
      .cfg_enable_in   (cfg_enable_in),
      .cfg_rank_in     (cfg_rank_in),
      .cfg_commit_in   (cfg_commit_in),
      .commit_done_out (commit_done_out),
      .red_out         (red_out),
      .green_out       (green_out),
      .blue_out        (blue_out),
      .hcount_out      (hcount_out),
      .vcount_out      (vcount_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic cfg_clear();
      cfg_valid_in  = 1'b0;
      cfg_layer_in  = 2'd0;
      cfg_enable_in = 1'b0;
      cfg_rank_in   = 2'd0;
      cfg_commit_in = 1'b0;
   endtask

   task automatic cfg_set(input logic valid, input logic [1:0] layer, input logic en,
                          input logic [1:0] rank, input logic commit);
      cfg_valid_in  = valid;
      cfg_layer_in  = layer;
      cfg_enable_in = en;
      cfg_rank_in   = rank;
      cfg_commit_in = commit;
   endtask

   // Drive one pixel, push its expectation, advance a clock, retire the oldest entry.
   task automatic step(input logic [10:0] h, input logic [9:0] v,
                       input logic [23:0] c0, input logic [23:0] c1,
                       input logic [23:0] c2, input logic [23:0] c3,
                       input logic chk, input logic [23:0] exp_color);
      exp_t e;
      hcount_in    = h;
      vcount_in    = v;
      layer_rgb_in = {c3, c2, c1, c0};
      e.chk = chk; e.color = exp_color; e.h = h; e.v = v;
      sb.push_back(e);
      @(posedge clk_in);
      #1;
      if (sb.size() == 2) begin
         e = sb.pop_front();
         if (e.chk) begin
            total++;
            if ({red_out, green_out, blue_out} !== e.color || hcount_out !== e.h ||
                vcount_out !== e.v) begin
               $display("FAIL pixel (%0d,%0d): got rgb=%h h=%0d v=%0d, want rgb=%h h=%0d v=%0d",
                        e.h, e.v, {red_out, green_out, blue_out}, hcount_out, vcount_out,
                        e.color, e.h, e.v);
            end else begin
               passed++;
            end
         end
      end
   endtask

   task automatic drain();
      step(11'd700, 10'd300, BLACK, BLACK, BLACK, BLACK, 1'b0, BLACK);
      step(11'd701, 10'd300, BLACK, BLACK, BLACK, BLACK, 1'b0, BLACK);
      sb.delete();
   endtask

   task automatic apply_reset();
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      hcount_in = 11'd5; vcount_in = 10'd5; layer_rgb_in = '0;
      cfg_clear();
      apply_reset();
      total++;
      if ({red_out, green_out, blue_out} !== BLACK || hcount_out !== 11'd0 || vcount_out !== 10'd0) begin
         $display("FAIL reset_outputs: got rgb=%h h=%0d v=%0d, want 000000 0 0",
                  {red_out, green_out, blue_out}, hcount_out, vcount_out);
      end else passed++;
      total++;
      if (commit_done_out !== 1'b0 || cfg_ready_out !== 1'b1) begin
         $display("FAIL reset_handshake: got done=%b ready=%b, want 0 1", commit_done_out, cfg_ready_out);
      end else passed++;
   endtask

   task automatic test_basic();
      step(11'd10, 10'd10, RED, GRN, BLU, WHT, 1'b1, RED);
      step(11'd11, 10'd10, RED, GRN, BLU, WHT, 1'b1, RED);
      step(11'd12, 10'd10, BLACK, GRN, BLU, WHT, 1'b1, GRN);
      step(11'd13, 10'd10, BLACK, BLACK, BLACK, BLACK, 1'b1, BLACK);
      step(11'd14, 10'd10, BLACK, BLACK, BLACK, WHT, 1'b1, WHT);
      drain();
   endtask

   // Reset config: all enabled, ranks 0..3, so the first opaque layer wins.
   task automatic test_back_to_back();
      logic [23:0] c [4];
      logic [23:0] want;
      for (int n = 0; n < 24; n++) begin
         for (int k = 0; k < 4; k++) begin
            c[k] = ($urandom_range(0, 1) == 0) ? BLACK : 24'($urandom);
         end
         want = BLACK;
         for (int k = 3; k >= 0; k--) begin
            if (c[k] != BLACK) want = c[k];
         end
         step(11'(300 + n), 10'(20 + n), c[0], c[1], c[2], c[3], 1'b1, want);
      end
      drain();
   endtask

   task automatic test_commit();
      int pulses = 0;
      cfg_set(1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
      step(11'd100, 10'd50, RED, GRN, BLU, WHT, 1'b1, RED);
      cfg_set(1'b1, 2'd0, 1'b1, 2'd3, 1'b1);
      step(11'd101, 10'd50, RED, GRN, BLU, WHT, 1'b1, RED);
      cfg_clear();
      total++;
      if (cfg_ready_out !== 1'b0) begin
         $display("FAIL wait_ready: got ready=%b, want 0", cfg_ready_out);
      end else passed++;
      cfg_set(1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
      step(11'd102, 10'd50, RED, GRN, BLU, WHT, 1'b1, RED);
      if (commit_done_out === 1'b1) pulses++;
      cfg_clear();
      step(11'd799, 10'd524, RED, GRN, BLU, WHT, 1'b1, RED);
      if (commit_done_out === 1'b1) pulses++;
      step(11'd0, 10'd0, RED, GRN, BLU, WHT, 1'b1, RED);
      total++;
      if (commit_done_out !== 1'b1) begin
         $display("FAIL commit_pulse: got done=%b after frame start, want 1", commit_done_out);
      end else passed++;
      step(11'd1, 10'd0, RED, GRN, BLU, WHT, 1'b1, BLU);
      if (commit_done_out === 1'b1) pulses++;
      step(11'd2, 10'd0, RED, GRN, BLACK, WHT, 1'b1, GRN);
      if (commit_done_out === 1'b1) pulses++;
      total++;
      if (pulses != 0 || cfg_ready_out !== 1'b1) begin
         $display("FAIL commit_single: got extra pulses=%0d ready=%b, want 0 1", pulses, cfg_ready_out);
      end else passed++;
      drain();
   endtask

   task automatic test_tie();
      cfg_set(1'b1, 2'd0, 1'b0, 2'd3, 1'b0);
      step(11'd200, 10'd100, RED, GRN, BLU, WHT, 1'b1, BLU);
      cfg_set(1'b1, 2'd2, 1'b1, 2'd2, 1'b0);
      step(11'd201, 10'd100, RED, GRN, BLU, WHT, 1'b1, BLU);
      cfg_set(1'b1, 2'd3, 1'b1, 2'd1, 1'b1);
      step(11'd202, 10'd100, RED, GRN, BLU, WHT, 1'b1, BLU);
      cfg_clear();
      step(11'd203, 10'd100, RED, GRN, BLU, WHT, 1'b1, BLU);
      step(11'd0, 10'd0, RED, GRN, BLU, WHT, 1'b1, BLU);
      total++;
      if (commit_done_out !== 1'b1) begin
         $display("FAIL tie_commit: got done=%b, want 1", commit_done_out);
      end else passed++;
      step(11'd1, 10'd0, RED, GRN, BLU, WHT, 1'b1, GRN);
      step(11'd2, 10'd0, RED, BLACK, BLU, WHT, 1'b1, WHT);
      step(11'd3, 10'd0, RED, BLACK, BLU, BLACK, 1'b1, BLU);
      drain();
   endtask

   task automatic test_reset_mid_wait();
      cfg_set(1'b1, 2'd1, 1'b0, 2'd1, 1'b1);
      step(11'd0, 10'd0, RED, GRN, BLU, WHT, 1'b1, GRN);
      cfg_clear();
      total++;
      if (cfg_ready_out !== 1'b0 || commit_done_out !== 1'b0) begin
         $display("FAIL commit_at_start: got ready=%b done=%b, want 0 0", cfg_ready_out, commit_done_out);
      end else passed++;
      step(11'd1, 10'd0, RED, GRN, BLU, WHT, 1'b1, GRN);
      total++;
      if (commit_done_out !== 1'b0) begin
         $display("FAIL commit_same_frame: got done=%b, want 0", commit_done_out);
      end else passed++;
      drain();
      apply_reset();
      step(11'd0, 10'd0, RED, GRN, BLU, WHT, 1'b1, RED);
      total++;
      if (commit_done_out !== 1'b0) begin
         $display("FAIL reset_abandon: got done=%b at frame start, want 0", commit_done_out);
      end else passed++;
      step(11'd1, 10'd0, BLACK, GRN, BLU, WHT, 1'b1, GRN);
      step(11'd2, 10'd0, BLACK, BLACK, BLACK, WHT, 1'b1, WHT);
      total++;
      if (commit_done_out !== 1'b0 || cfg_ready_out !== 1'b1) begin
         $display("FAIL reset_idle: got done=%b ready=%b, want 0 1", commit_done_out, cfg_ready_out);
      end else passed++;
      drain();
   endtask

   initial begin
      rst_in = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_commit();
      test_tie();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
